// File: rtl/minon_loader_pkg.sv
// Shared types for the program loader and the CPU instruction cache.
// Optional checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package minon_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam logic [7:0] LOADER_MAGIC_DEFAULT = 8'hA5;

  // Instruction word as seen by the CPU instCache write port.
  typedef logic [31:0] word_t;

  typedef logic [1:0] lane_t;
  localparam lane_t LANE_LAST = 2'd3;

endpackage

// File: rtl/loader_word_pack.sv
// Packs four little-endian bytes into one instruction word; emits a
// one-cycle word_valid pulse the cycle after the fourth byte is taken.
module loader_word_pack
  import minon_loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  output logic       o_lane_last,
  output logic       o_word_valid,
  output word_t      o_word
);

  lane_t       r_lane;
  logic [23:0] r_acc;
  logic        r_word_valid;
  word_t       r_word;

  assign o_lane_last  = (r_lane == LANE_LAST);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lane       <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_lane <= '0;
      end else if (i_byte_valid) begin
        r_lane <= r_lane + 2'd1;
        if (r_lane == LANE_LAST) begin
          r_word_valid <= 1'b1;
          r_word       <= {i_byte, r_acc};
        end
      end
    end
  end

  // Shift right so byte 0 lands in the low lane after three shifts.
  always_ff @(posedge i_clk) begin
    // NOTE: no reset here; every lane is rewritten by the current word's bytes before it is read.
    if (i_byte_valid) begin
      r_acc <= {i_byte, r_acc[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into the instruction cache; holds the CPU until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module prog_loader
  import minon_loader_pkg::*;
#(
  parameter int          ADDR_W        = 8,
  parameter int unsigned START_ADDR    = 0,
  parameter logic [7:0]  MAGIC         = LOADER_MAGIC_DEFAULT,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output word_t             imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0]       CAPACITY = 17'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e PAYLOAD_END = CSUM;
`else
  localparam loader_state_e PAYLOAD_END = DONE;
`endif

  loader_state_e     r_state;
  loader_state_e     w_next_state;
  logic              w_accept;
  logic              w_start;
  logic              w_data_byte;
  logic              w_lane_last;
  logic              w_last_word;
  logic              w_word_valid;
  word_t             w_word;
  logic [15:0]       w_count;
  logic [7:0]        r_count_lo;
  logic [15:0]       r_count;
  logic [15:0]       r_word_cnt;
  logic [ADDR_W-1:0] r_imem_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_accept    = in_valid & in_ready;
  assign w_start     = w_accept && (in_data == MAGIC) && (r_state == IDLE || r_state == DONE);
  assign w_data_byte = w_accept && (r_state == DATA);
  assign w_count     = {in_data, r_count_lo};
  assign w_last_word = (r_word_cnt == r_count - 16'd1);

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves w_next_state unassigned (latch).
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start) w_next_state = LEN0;
      end
      LEN0: begin
        if (w_accept) w_next_state = LEN1;
      end
      LEN1: begin
        if (w_accept) begin
          if (w_count == 16'd0)                w_next_state = PAYLOAD_END;
          else if ({1'b0, w_count} > CAPACITY) w_next_state = ERR;
          else                                 w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_data_byte && w_lane_last && w_last_word) w_next_state = PAYLOAD_END;
      end
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept) w_next_state = (in_data == r_csum) ? DONE : ERR;
`else
        w_next_state = ERR;
`endif
      end
      ERR:     w_next_state = ERR;
      default: w_next_state = ERR;
    endcase
  end

  // Moore outputs; IDLE is only reachable through RESET, so it carries the reset hold value.
  always_comb begin
    in_ready = (r_state != ERR);
    done     = (r_state == DONE);
    error    = (r_state == ERR);
    cpu_hold = (r_state == IDLE) ? HOLD_AT_RESET : (r_state != DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_count_lo  <= '0;
      r_count     <= '0;
      r_word_cnt  <= '0;
      r_imem_addr <= START;
    end else begin
      if (w_start) r_word_cnt <= '0;
      if (r_state == LEN0 && w_accept) r_count_lo <= in_data;
      if (r_state == LEN1 && w_accept) r_count <= w_count;
      // Address is registered alongside the packed word so both appear with imem_we.
      if (w_data_byte && w_lane_last) begin
        r_imem_addr <= START + ADDR_W'(r_word_cnt);
        r_word_cnt  <= r_word_cnt + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_data_byte) begin
      r_csum <= r_csum ^ in_data;
    end
  end
`endif

  loader_word_pack u_word_pack (
    .i_clk        (CLOCK_50),
    .i_reset      (RESET),
    .i_clear      (w_start),
    .i_byte_valid (w_data_byte),
    .i_byte       (in_data),
    .o_lane_last  (w_lane_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign imem_we    = w_word_valid;
  assign imem_wdata = w_word;
  assign imem_addr  = r_imem_addr;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus
// and popped by a monitor on every imem_we; status flags are checked directly.
module tb_prog_loader;

  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic              CLOCK_50 = 1'b0;
  logic              RESET;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  wr_t     exp_q[$];
  wr_t     mon_e;
  byte_q_t q;
  int      n_cmp = 0;
  int      n_bad = 0;

  prog_loader #(
    .ADDR_W        (ADDR_W),
    .START_ADDR    (0),
    .MAGIC         (8'hA5),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Status packed as {done, error, cpu_hold, in_ready}.
  task automatic check_status(input string name, input logic [3:0] exp);
    check(name, {60'd0, done, error, cpu_hold, in_ready}, {60'd0, exp});
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (imem_we === 1'b1) begin
      check("we_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {56'd0, imem_addr}, {56'd0, mon_e.addr});
        check("wr_data", {32'd0, imem_wdata}, {32'd0, mon_e.data});
      end
    end
  end

  // Random idle gaps with junk on in_data; the byte is taken on the following edge.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge CLOCK_50); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t bq);
    foreach (bq[i]) send_byte(bq[i]);
  endtask

  task automatic settle_and_drain(input string name);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RESET    = 1'b1;
    @(posedge CLOCK_50); #1;
    RESET    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_status("reset_status", 4'b0011);
    check("reset_we",    {63'd0, imem_we}, 64'd0);
    check("reset_addr",  {56'd0, imem_addr}, 64'd0);
    check("reset_wdata", {32'd0, imem_wdata}, 64'd0);
    RESET = 1'b0;

    // Two-word load (plus matching checksum C8 when enabled).
    exp_q.push_back('{addr: 8'h00, data: 32'hCC000000});
    exp_q.push_back('{addr: 8'h01, data: 32'h04030201});
    q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCC, 8'h01, 8'h02, 8'h03};
    send_bytes(q);
    check_status("t1_before_last", 4'b0011);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h04);
    check_status("t2_before_csum", 4'b0011);
    send_byte(8'hC8);
`else
    send_byte(8'h04);
`endif
    check_status("t1_done", 4'b1001);
    settle_and_drain("t1_drain");

    // Reload from DONE restarts at START_ADDR.
    send_byte(8'hA5);
    check_status("t6_hold_after_magic", 4'b0011);
    exp_q.push_back('{addr: 8'h00, data: 32'h44332211});
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(q);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    check_status("t6_done", 4'b1001);
    settle_and_drain("t6_drain");

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words still written, then sticky error.
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 32'hCC000000});
    exp_q.push_back('{addr: 8'h01, data: 32'h04030201});
    q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_bytes(q);
    check_status("t2_bad_csum", 4'b0110);
    settle_and_drain("t2_drain");
`endif

    // Noise then zero-length frame.
    do_reset();
    q = '{8'h13, 8'h37, 8'hA5, 8'h00};
    send_bytes(q);
    check_status("t3_before_cnt_hi", 4'b0011);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
    send_byte(8'h00);
`else
    send_byte(8'h00);
`endif
    check_status("t3_done", 4'b1001);
    settle_and_drain("t3_no_writes");

    // Overlong count 257 errors the cycle after CNT_HI; later bytes ignored.
    do_reset();
    q = '{8'hA5, 8'h01};
    send_bytes(q);
    check_status("t4_before_cnt_hi", 4'b0011);
    send_byte(8'h01);
    check_status("t4_error", 4'b0110);
    send_byte(8'hA5);
    check_status("t4_error_sticky", 4'b0110);
    settle_and_drain("t4_no_writes");

    // Count exactly 2**ADDR_W is legal.
    do_reset();
    q = '{8'hA5, 8'h00, 8'h01};
    send_bytes(q);
    check_status("cap_boundary_ok", 4'b0011);

    // Reset after two of four payload bytes, then a clean frame.
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(q);
    do_reset();
    check_status("t5_after_reset", 4'b0011);
    check("t5_addr", {56'd0, imem_addr}, 64'd0);
    settle_and_drain("t5_no_partial_write");
    exp_q.push_back('{addr: 8'h00, data: 32'hEFBEADDE});
    q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_bytes(q);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    check_status("t5_done", 4'b1001);
    settle_and_drain("t5_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
